// File: rtl/marquee_pkg.sv
// marquee_pkg: shared definitions for the scrolling seven-segment marquee.
//   state_t     controller states (IDLE, RUN, PAUSE)
//   SEG_BLANK   active-low pattern with every segment off
//   SEG_D0..9   active-low digit patterns, bit order {g,f,e,d,c,b,a}
//   NPOS        number of scroll positions (0..NPOS-1)
//   stream_nib  digit nibble shown at a given index of the virtual stream
package marquee_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_D0 = 7'h40;
    localparam logic [6:0] SEG_D1 = 7'h79;
    localparam logic [6:0] SEG_D2 = 7'h24;
    localparam logic [6:0] SEG_D3 = 7'h30;
    localparam logic [6:0] SEG_D4 = 7'h19;
    localparam logic [6:0] SEG_D5 = 7'h12;
    localparam logic [6:0] SEG_D6 = 7'h02;
    localparam logic [6:0] SEG_D7 = 7'h78;
    localparam logic [6:0] SEG_D8 = 7'h00;
    localparam logic [6:0] SEG_D9 = 7'h10;

    localparam int         NPOS    = 6;
    localparam logic [2:0] POS_MAX = 3'(NPOS - 1);

    // Any non-BCD nibble decodes to blank, so 4'hF stands in for a blank slot.
    localparam logic [3:0] NIB_BLANK = 4'hF;

    // Stream is {B,B,B,MSG[11:8],MSG[7:4],MSG[3:0],B,B}; index 0 is leftmost.
    function automatic logic [3:0] stream_nib(input logic [11:0] msg,
                                              input logic [3:0]  idx);
        logic [3:0] nib;
        case (idx)
            4'd3:    nib = msg[11:8];
            4'd4:    nib = msg[7:4];
            4'd5:    nib = msg[3:0];
            default: nib = NIB_BLANK;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/marquee_ctrl_seg7_dec.sv
// seg7_dec: BCD digit to active-low seven-segment pattern.
//   bcd  in  4  digit value; 10..15 produce a blank pattern
//   seg  out 7  active-low segments {g,f,e,d,c,b,a}
module seg7_dec
    import marquee_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_D0;
            4'd1:    seg = SEG_D1;
            4'd2:    seg = SEG_D2;
            4'd3:    seg = SEG_D3;
            4'd4:    seg = SEG_D4;
            4'd5:    seg = SEG_D5;
            4'd6:    seg = SEG_D6;
            4'd7:    seg = SEG_D7;
            4'd8:    seg = SEG_D8;
            4'd9:    seg = SEG_D9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/marquee_ctrl.sv
// marquee_ctrl: run/pause/stop sequencer for a three-digit scrolling display.
// Parameters:
//   DIV_BASE  tick period is 2^(DIV_BASE-speed) clk cycles (legal 4..31)
//   MSG       three BCD digits, [11:8] leftmost when fully on screen
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   btn_run    in   run button, active-high, asynchronous to clk
//   btn_pause  in   pause/stop button, active-high, asynchronous to clk
//   dir        in   0 = scroll left (pos up), 1 = scroll right (pos down)
//   speed      in   tick-rate select, 0 = slowest
//   seg3/2/1   out  registered active-low segments, seg3 leftmost
//   pos        out  scroll position 0..5
//   running    out  high while in RUN
// Build option:
//   MARQUEE_BOUNCE_EN  ping-pong scrolling instead of wrapping; direction is
//                      latched from dir when leaving IDLE and flips at the ends.
module marquee_ctrl
    import marquee_pkg::*;
#(
    parameter int          DIV_BASE = 24,
    parameter logic [11:0] MSG      = 12'h123
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_pause,
    input  logic       dir,
    input  logic [1:0] speed,
    output logic [6:0] seg3,
    output logic [6:0] seg2,
    output logic [6:0] seg1,
    output logic [2:0] pos,
    output logic       running
);

    state_t              state;
    logic [DIV_BASE-1:0] presc;
    logic [DIV_BASE-1:0] term;
    logic                tick;

    // [0] first sync flop, [1] second sync flop, [2] previous synced value
    logic [2:0] run_sync;
    logic [2:0] pause_sync;
    logic       run_ev;
    logic       pause_ev;

    logic [3:0] nib3_p0, nib2_p0, nib1_p0;
    logic [6:0] dec3_p0, dec2_p0, dec1_p0;

`ifdef MARQUEE_BOUNCE_EN
    logic dir_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_sync   <= '0;
            pause_sync <= '0;
        end else begin
            run_sync   <= {run_sync[1:0], btn_run};
            pause_sync <= {pause_sync[1:0], btn_pause};
        end
    end

    assign run_ev   = run_sync[1] & ~run_sync[2];
    assign pause_ev = pause_sync[1] & ~pause_sync[2];

    // 2^(DIV_BASE-speed)-1 is all-ones shifted right by speed. Using >= means a
    // speed-up that leaves the count beyond the new terminal ticks right away.
    assign term = {DIV_BASE{1'b1}} >> speed;
    assign tick = (presc >= term);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pos     <= '0;
            presc   <= '0;
            running <= 1'b0;
`ifdef MARQUEE_BOUNCE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pos   <= '0;
                    presc <= '0;
                    // pause_ev has priority, so both buttons together stay idle
                    if (run_ev && !pause_ev) begin
                        state   <= RUN;
                        running <= 1'b1;
`ifdef MARQUEE_BOUNCE_EN
                        dir_q   <= dir;
`endif
                    end
                end
                RUN: begin
                    if (pause_ev) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        presc <= '0;
`ifdef MARQUEE_BOUNCE_EN
                        if (!dir_q) begin
                            if (pos == POS_MAX) begin
                                dir_q <= 1'b1;
                                pos   <= pos - 3'd1;
                            end else begin
                                pos   <= pos + 3'd1;
                            end
                        end else begin
                            if (pos == 3'd0) begin
                                dir_q <= 1'b0;
                                pos   <= pos + 3'd1;
                            end else begin
                                pos   <= pos - 3'd1;
                            end
                        end
`else
                        if (dir) begin
                            pos <= (pos == 3'd0) ? POS_MAX : pos - 3'd1;
                        end else begin
                            pos <= (pos == POS_MAX) ? 3'd0 : pos + 3'd1;
                        end
`endif
                    end else begin
                        presc <= presc + DIV_BASE'(1);
                    end
                end
                PAUSE: begin
                    if (pause_ev) begin
                        state <= IDLE;
                        pos   <= '0;
                        presc <= '0;
`ifdef MARQUEE_BOUNCE_EN
                        dir_q <= 1'b0;
`endif
                    end else if (run_ev) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Stage p0: pick the three visible stream slots for the current position
    assign nib3_p0 = stream_nib(MSG, {1'b0, pos});
    assign nib2_p0 = stream_nib(MSG, {1'b0, pos} + 4'd1);
    assign nib1_p0 = stream_nib(MSG, {1'b0, pos} + 4'd2);

    seg7_dec u_dec3 (.bcd(nib3_p0), .seg(dec3_p0));
    seg7_dec u_dec2 (.bcd(nib2_p0), .seg(dec2_p0));
    seg7_dec u_dec1 (.bcd(nib1_p0), .seg(dec1_p0));

    // Stage p1: registered segment outputs, one cycle behind pos
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg3 <= SEG_BLANK;
            seg2 <= SEG_BLANK;
            seg1 <= SEG_BLANK;
        end else begin
            seg3 <= dec3_p0;
            seg2 <= dec2_p0;
            seg1 <= dec1_p0;
        end
    end

endmodule

// File: tb/tb_marquee_ctrl.sv
// tb_marquee_ctrl: randomized and directed bench for marquee_ctrl with a
// behavioural model of the marquee (mode, position, elapsed count).
`timescale 1ns/1ps
module tb_marquee_ctrl;

    localparam int          DB   = 4;
    localparam logic [11:0] MSGV = 12'h123;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_run;
    logic       btn_pause;
    logic       dir;
    logic [1:0] speed;
    logic [6:0] seg3, seg2, seg1;
    logic [2:0] pos;
    logic       running;

    marquee_ctrl #(.DIV_BASE(DB), .MSG(MSGV)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_pause (btn_pause),
        .dir       (dir),
        .speed     (speed),
        .seg3      (seg3),
        .seg2      (seg2),
        .seg1      (seg1),
        .pos       (pos),
        .running   (running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_mode;   // 0 idle, 1 run, 2 pause
    int         m_pos;
    int         m_cnt;    // clk cycles elapsed in the current tick period
    bit         m_bdir;
    logic [6:0] m_s3, m_s2, m_s1;
    bit         run_hist [4];   // [0] sample at this edge, [k] k edges ago
    bit         pause_hist [4];

    function automatic logic [6:0] glyph(input int i);
        int         nib;
        logic [6:0] lit;
        case (i)
            3:       nib = int'(MSGV[11:8]);
            4:       nib = int'(MSGV[7:4]);
            5:       nib = int'(MSGV[3:0]);
            default: nib = 15;
        endcase
        // active-high segment sets {g,f,e,d,c,b,a}
        case (nib)
            0: lit = 7'h3F;  1: lit = 7'h06;  2: lit = 7'h5B;  3: lit = 7'h4F;
            4: lit = 7'h66;  5: lit = 7'h6D;  6: lit = 7'h7D;  7: lit = 7'h07;
            8: lit = 7'h7F;  9: lit = 7'h6F;
            default: lit = 7'h00;
        endcase
        return ~lit;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_cnt = 0; m_bdir = 0;
        m_s3 = 7'h7F; m_s2 = 7'h7F; m_s1 = 7'h7F;
        for (int k = 0; k < 4; k++) begin
            run_hist[k]   = 0;
            pause_hist[k] = 0;
        end
    endtask

    task automatic advance();
`ifdef MARQUEE_BOUNCE_EN
        if (!m_bdir) begin
            if (m_pos == 5) begin m_bdir = 1; m_pos = 4; end
            else m_pos = m_pos + 1;
        end else begin
            if (m_pos == 0) begin m_bdir = 0; m_pos = 1; end
            else m_pos = m_pos - 1;
        end
`else
        m_pos = dir ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
`endif
    endtask

    task automatic model_step();
        bit rev, pev;
        int period;
        for (int k = 3; k > 0; k--) begin
            run_hist[k]   = run_hist[k-1];
            pause_hist[k] = pause_hist[k-1];
        end
        run_hist[0]   = btn_run;
        pause_hist[0] = btn_pause;
        // a button acts on the third edge after it is first seen high
        rev = run_hist[2] && !run_hist[3];
        pev = pause_hist[2] && !pause_hist[3];
        // segment outputs show the position held before this edge
        m_s3 = glyph(m_pos);
        m_s2 = glyph(m_pos + 1);
        m_s1 = glyph(m_pos + 2);
        period = 1 << (DB - int'(speed));
        case (m_mode)
            0: if (rev && !pev) begin
                   m_mode = 1;
                   m_bdir = dir;
               end
            1: if (pev) m_mode = 2;
               else if (m_cnt >= period - 1) begin
                   m_cnt = 0;
                   advance();
               end else m_cnt = m_cnt + 1;
            default: if (pev) begin
                   m_mode = 0; m_pos = 0; m_cnt = 0; m_bdir = 0;
               end else if (rev) m_mode = 1;
        endcase
    endtask

    task automatic check_all();
        check("pos", 32'(pos), 32'(m_pos));
        check("running", 32'(running), 32'(m_mode == 1));
        check("seg3", 32'(seg3), 32'(m_s3));
        check("seg2", 32'(seg2), 32'(m_s2));
        check("seg1", 32'(seg1), 32'(m_s1));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic press_run();
        btn_run = 1'b1; step(); btn_run = 1'b0; step();
    endtask

    task automatic press_pause();
        btn_pause = 1'b1; step(); btn_pause = 1'b0; step();
    endtask

    // Called just after a step; asserts reset between clock edges.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk) rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; btn_run = 1'b0; btn_pause = 1'b0; dir = 1'b0; speed = 2'd0;
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst = 1'b1;

        // idle hold after reset
        repeat (100) step();

        // start forward scrolling and find position 3
        press_run();
        for (int i = 0; i < 200 && m_pos != 3; i++) step();
        check("reach_p3", 32'(pos), 32'd3);
        step();
        check("seg_p3", 32'({seg3, seg2, seg1}), 32'({7'h79, 7'h24, 7'h30}));
        repeat (80) step();

        // reverse at a faster rate
        dir = 1'b1; speed = 2'd2;
        repeat (40) step();

        // pause at position 3, resume, then pause twice to stop
        dir = 1'b0; speed = 2'd0;
        for (int i = 0; i < 400 && !(m_pos == 3 && m_mode == 1); i++) step();
        check("reach_p3_run", 32'(pos), 32'd3);
        press_pause();
        repeat (50) step();
        press_run();
        repeat (30) step();
        press_pause();
        repeat (5) step();
        press_pause();
        repeat (10) step();

        // both buttons together: idle stays idle, run goes to pause
        btn_run = 1'b1; btn_pause = 1'b1; step();
        btn_run = 1'b0; btn_pause = 1'b0;
        repeat (6) step();
        press_run();
        repeat (10) step();
        btn_run = 1'b1; btn_pause = 1'b1; step();
        btn_run = 1'b0; btn_pause = 1'b0;
        repeat (6) step();
        press_pause();
        repeat (4) step();

        // asynchronous reset in the middle of a tick period
        press_run();
        repeat (23) step();
        dir = ~dir;
        repeat (7) step();
        async_reset();
        repeat (5) step();

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            btn_run   = ($urandom_range(0, 24) == 0);
            btn_pause = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) dir = 1'($urandom);
            if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                btn_run = 1'b1; btn_pause = 1'b1;
            end
            step();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/marquee_ctrl.md
# marquee_ctrl

Sequencing controller for the three-digit seven-segment scrolling message display. Owns the scroll position, the tick prescaler and a run/pause/stop state machine driven by two push-buttons, and produces registered active-low segment patterns for `seg3` (leftmost), `seg2` and `seg1`. Replaces the free-running divider-plus-counter arrangement, so the display can be started, paused, stopped, sped up and reversed at run time.

## Interface
- `DIV_BASE`, default 24: tick period is 2^(DIV_BASE−speed) clk cycles; legal range 4..31.
- `MSG`, default 12'h123: three BCD digits, [11:8] shown leftmost when fully on screen.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_run`  in  1  run button, active-high, asynchronous to clk.
- `btn_pause`  in  1  pause/stop button, active-high, asynchronous to clk.
- `dir`  in  1  0 = scroll left (pos increments), 1 = scroll right (pos decrements).
- `speed`  in  2  tick-rate select, 0 = slowest.
- `seg3`, `seg2`, `seg1`  out  7 each  active-low segments {g,f,e,d,c,b,a}.
- `pos`  out  3  current scroll position, 0..5.
- `running`  out  1  high while in RUN.

## Operation
- Virtual stream S = {B,B,B,MSG[11:8],MSG[7:4],MSG[3:0],B,B}, B = blank (7'h7F). Position p shows {seg3,seg2,seg1} = {S[p],S[p+1],S[p+2]}; for MSG 12'h123: p0 "   ", p1 "  1", p2 " 12", p3 "123", p4 "23 ", p5 "3  ".
- Buttons: two-flop synchronizer, then rising-edge detect → one-cycle `run_ev` / `pause_ev`.
- FSM states IDLE, RUN, PAUSE:
  - IDLE: pos = 0, prescaler = 0. `run_ev` → RUN.
  - RUN: prescaler counts; on terminal count, tick: pos advances per `dir`, prescaler clears. `pause_ev` → PAUSE.
  - PAUSE: pos and prescaler frozen. `run_ev` → RUN (prescaler resumes from held value). `pause_ev` → IDLE (pos and prescaler cleared).
  - `run_ev` and `pause_ev` in the same cycle: `pause_ev` wins.
- Wrap: forward 5→0; reverse 0→5. `dir` is sampled only on the tick cycle.
- Speed change mid-period: terminal = 2^(DIV_BASE−speed)−1; if prescaler ≥ new terminal, tick on next cycle and clear. Prescaler width DIV_BASE bits.
- Non-BCD MSG digits (A–F) display as blank.

## Timing
- Reset (async assert, sync release): state IDLE, pos 0, prescaler 0, all segs 7'h7F, running 0.
- Button rise → state change on 3rd rising clk edge after the button is stable high (2 sync + 1 edge).
- Tick → `pos` updates same edge; `seg*` update one cycle later (registered decode); `running` registered with state.
- First tick after IDLE→RUN occurs exactly 2^(DIV_BASE−speed) cycles after entering RUN.
- Reset mid-scroll: immediate return to reset values; no stale pattern for any cycle.

## Configuration
- `MARQUEE_BOUNCE_EN` defined: ping-pong scrolling. Direction register loads from `dir` on IDLE→RUN; at pos 5 (moving forward) or pos 0 (moving backward) the direction register flips and pos steps back, never wrapping (…4,5,4,3…1,0,1…). `dir` ignored during RUN/PAUSE. Direction register resets to 0 and clears on PAUSE→IDLE.
- Not defined: wrap behaviour above; `dir` live.

## Structure
- Shared package `marquee_pkg`: state enum (IDLE, RUN, PAUSE), `SEG_BLANK` = 7'h7F, digit pattern constants 0–9 (active-low), `NPOS` = 6.
- One sub-module: `seg7_dec` (4-bit BCD → 7-bit active-low, non-BCD → blank), instantiated three times. Synchronizer, edge detect, FSM and prescaler stay in `marquee_ctrl`.

## Test plan
- Reset with DIV_BASE=4, speed 0: segs all 7'h7F, pos 0, running 0; hold 100 cycles, nothing changes.
- `btn_run` pulse, dir 0: running high 3 cycles later; pos 1,2,3,4,5,0 every 16 cycles; at pos 3 segs = {7'h79,7'h24,7'h30} one cycle after the tick.
- dir 1, speed 2: pos steps 0→5→4 every 4 cycles.
- `pause_ev` at pos 3 → frozen 50 cycles; `btn_run` → next tick after the remaining prescaler count; second pause from PAUSE → IDLE, pos 0, segs blank.
- Both buttons rise in the same cycle during RUN → PAUSE; during IDLE → stays IDLE.
- With `MARQUEE_BOUNCE_EN`: start dir 0 → pos 0,1,2,3,4,5,4,3,2,1,0,1; toggling `dir` mid-run has no effect; async reset asserted mid-period → all outputs at reset values immediately.
